// File: rtl/input_conditioner.sv
// Debounces a noisy asynchronous switch level: two-flop synchronizer, a four-state
// qualification FSM, and registered clean level, edge strobes and busy flag.
module input_conditioner #(
    parameter int DEBOUNCE_N = 4
) (
    input  logic clock,
    input  logic reset_b,
    input  logic raw_in,
    output logic In,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int CNT_W = (DEBOUNCE_N <= 2) ? 1 : $clog2(DEBOUNCE_N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       sync_reg;
    logic             sync_s;
    logic             in_reg, in_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic             busy_reg, busy_next;

    // Only the second synchronizer flop is allowed to reach the FSM.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], raw_in};
        end
    end

    assign sync_s = sync_reg[1];

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state_reg <= IDLE_LOW;
            cnt_reg   <= '0;
            in_reg    <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            in_reg    <= in_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE_LOW: begin
                if (sync_s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_s) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!sync_s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_s) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        in_next   = (state_next == IDLE_HIGH) || (state_next == WAIT_LOW);
        busy_next = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
        rise_next = (state_reg == WAIT_HIGH) && (state_next == IDLE_HIGH);
        fall_next = (state_reg == WAIT_LOW) && (state_next == IDLE_LOW);
    end

    assign In         = in_reg;
    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed bench for input_conditioner, compared against a
// run-length debounce model fed by a two-sample delay of raw_in.
module tb_input_conditioner;

    localparam int N = 4;

    logic clock   = 1'b0;
    logic reset_b = 1'b0;
    logic raw_in  = 1'b0;
    logic In, rise_pulse, fall_pulse, busy;

    int total = 0;
    int bad   = 0;

    logic [1:0] m_hist = 2'b00;
    logic       m_in   = 1'b0;
    logic       m_rise = 1'b0;
    logic       m_fall = 1'b0;
    logic       m_busy = 1'b0;
    int         m_run  = 0;

    int rise_cnt = 0, fall_cnt = 0, m_rise_cnt = 0, m_fall_cnt = 0;

    input_conditioner #(.DEBOUNCE_N(N)) dut (
        .clock      (clock),
        .reset_b    (reset_b),
        .raw_in     (raw_in),
        .In         (In),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Accept a level once N consecutive synchronized samples disagree with it.
    task automatic model_edge();
        logic s;
        if (!reset_b) begin
            m_hist = 2'b00;
            m_in   = 1'b0;
            m_run  = 0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_busy = 1'b0;
        end else begin
            s      = m_hist[1];
            m_hist = {m_hist[0], raw_in};
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s != m_in) begin
                m_run++;
                if (m_run == N) begin
                    m_in   = s;
                    m_rise = s;
                    m_fall = !s;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_busy = (m_run != 0);
        end
    endtask

    task automatic tick(input logic raw, input logic rst_b);
        raw_in  = raw;
        reset_b = rst_b;
        @(posedge clock);
        model_edge();
        #1;
        check_eq("In", In, m_in);
        check_eq("rise_pulse", rise_pulse, m_rise);
        check_eq("fall_pulse", fall_pulse, m_fall);
        check_eq("busy", busy, m_busy);
        if (rise_pulse) rise_cnt++;
        if (fall_pulse) fall_cnt++;
        if (m_rise) m_rise_cnt++;
        if (m_fall) m_fall_cnt++;
    endtask

    initial begin
        int base_rise, base_fall, len;
        logic lvl;

        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_eq("reset_in", In, 0);
        check_eq("reset_busy", busy, 0);
        $display("txn reset: In=%0d busy=%0d", In, busy);

        // Rise latency: index i corresponds to edge Ei.
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1);
            if (i >= 2 && i <= 4) check_eq("rise_busy_window", busy, 1);
            if (i == 4) check_eq("rise_in_before_E5", In, 0);
            if (i == 5) begin
                check_eq("rise_in_E5", In, 1);
                check_eq("rise_pulse_E5", rise_pulse, 1);
            end
            if (i == 6) check_eq("rise_pulse_E6", rise_pulse, 0);
        end
        $display("txn rise: In=%0d rises=%0d", In, rise_cnt);

        base_rise = rise_cnt;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1);
            if (i == 5) begin
                check_eq("fall_in_E5", In, 0);
                check_eq("fall_pulse_E5", fall_pulse, 1);
            end
            if (i == 6) check_eq("fall_pulse_E6", fall_pulse, 0);
        end
        check_eq("fall_no_rise", rise_cnt - base_rise, 0);
        $display("txn fall: In=%0d falls=%0d", In, fall_cnt);

        base_rise = rise_cnt;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
        check_eq("glitch_in", In, 0);
        check_eq("glitch_rise", rise_cnt - base_rise, 0);
        check_eq("glitch_busy", busy, 0);
        $display("txn glitch: In=%0d busy=%0d", In, busy);

        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        check_eq("wl_busy", busy, 1);
        check_eq("wl_in", In, 1);
        base_fall = fall_cnt;
        tick(1'b1, 1'b0);
        check_eq("rst_in", In, 0);
        check_eq("rst_busy", busy, 0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1);
            if (i == 4) check_eq("rel_in_R5", In, 0);
            if (i == 5) check_eq("rel_in_R6", In, 1);
        end
        check_eq("rst_no_fall", fall_cnt - base_fall, 0);
        $display("txn reset_in_wait_low: In=%0d falls=%0d", In, fall_cnt);

        base_rise = rise_cnt;
        base_fall = fall_cnt;
        for (int i = 0; i < 50; i++) tick(i[0], 1'b1);
        check_eq("toggle_in", In, 1);
        check_eq("toggle_pulses", (rise_cnt - base_rise) + (fall_cnt - base_fall), 0);
        $display("txn toggle50: In=%0d", In);

        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
        base_rise = rise_cnt;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
        check_eq("hold10_rises", rise_cnt - base_rise, 1);
        check_eq("hold10_in", In, 1);
        $display("txn hold10: In=%0d rises=%0d", In, rise_cnt - base_rise);

        for (int b = 0; b < 250; b++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 49) == 0) begin
                tick(lvl, 1'b0);
                $display("txn rand %0d: reset", b);
            end else begin
                for (int i = 0; i < len; i++) tick(lvl, 1'b1);
                $display("txn rand %0d: raw=%0d len=%0d In=%0d", b, lvl, len, In);
            end
        end

        check_eq("rise_total", rise_cnt, m_rise_cnt);
        check_eq("fall_total", fall_cnt, m_fall_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
